// File: rtl/ram_pkg.sv
// Shared defaults and sweep-state encoding for the ram block and its clear sequencer.
package ram_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 8;
    localparam int RAM_DEPTH  = 2 ** RAM_ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } sweep_state_e;

endpackage : ram_pkg

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, while busy is high.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output gets a default first so this block can never infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        clear_we = 1'b0;
        case (state_q)
            CLEAR: begin
                busy     = 1'b1;
                clear_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign clear_addr = cnt_q;

endmodule : ram_clear_seq

// File: rtl/ram.sv
// Single-port synchronous RAM with registered read and a self-clearing sweep after reset.
module ram
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic              select,
    output logic              busy
);

    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;

    ram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    logic              user_we;
    logic              user_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] data_out_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // The sweep owns the single port while busy; user requests are simply dropped.
    always_comb begin
        user_we   = select & write & ~busy;
        user_re   = select & ~write & ~busy;
        mem_we    = clear_we | user_we;
        mem_addr  = busy ? clear_addr : address;
        mem_wdata = busy ? '0 : data_in;
    end

    // NOTE: the array has no reset so it maps to block RAM; the clear sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (user_re) begin
            data_out_q <= mem[mem_addr];
        end
    end

    assign data_out = data_out_q;

endmodule : ram

// File: tb/tb_ram.sv
// Randomized self-checking bench for ram against an array-based reference model.
module tb_ram;
    import ram_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          write;
    logic          select;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          busy;

    always #5 clk = ~clk;

    ram #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_out (data_out),
        .data_in  (data_in),
        .address  (address),
        .write    (write),
        .select   (select),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory contents, last read value, sweep cycles remaining.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;
    int            ref_busy_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the edge, compare on the falling edge.
    task automatic step(input logic r, input logic s, input logic w, input int a, input int d);
        rst     = r;
        select  = s;
        write   = w;
        address = AW'(a);
        data_in = DW'(d);
        @(posedge clk);
        if (r) begin
            ref_dout      = '0;
            ref_busy_left = DEPTH;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else if (ref_busy_left > 0) begin
            ref_busy_left--;
        end else if (s && w) begin
            ref_mem[a % DEPTH] = DW'(d);
        end else if (s) begin
            ref_dout = ref_mem[a % DEPTH];
        end
        @(negedge clk);
        check("busy", {31'd0, busy}, {31'd0, ref_busy_left > 0});
        check("data_out", {24'd0, data_out}, {24'd0, ref_dout});
    endtask

    // Idle until busy falls, bounded; pokes write/read requests that must be dropped.
    task automatic wait_sweep(output int cycles);
        cycles = 0;
        while (busy && cycles < 2000) begin
            if (cycles < 8)       step(1'b0, 1'b1, 1'b1, 9, 'h55);
            else if (cycles < 16) step(1'b0, 1'b1, 1'b0, 37, 0);
            else                  step(1'b0, 1'b0, 1'b0, 0, 0);
            cycles++;
        end
    endtask

    initial begin
        int cycles;
        int a;
        logic [DW-1:0] held;

        rst = 1'b0; select = 1'b0; write = 1'b0; address = '0; data_in = '0;
        ref_dout = '0; ref_busy_left = DEPTH;
        foreach (ref_mem[i]) ref_mem[i] = '0;

        // Reset and sweep length
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_dout", {24'd0, data_out}, 32'd0);
        wait_sweep(cycles);
        check("sweep_len", cycles, 1024);
        step(1'b0, 1'b1, 1'b0, 500, 0);
        check("rd500_after_clear", {24'd0, data_out}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 9, 0);
        check("rd9_write_dropped", {24'd0, data_out}, 32'd0);

        // Fill with 2k mod 256
        for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 1'b1, k, (2 * k) % 256);
        check("dout_held_on_write", {24'd0, data_out}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 37, 0);   check("rd37",   {24'd0, data_out}, 32'd74);
        step(1'b0, 1'b1, 1'b0, 200, 0);  check("rd200",  {24'd0, data_out}, 32'd144);
        step(1'b0, 1'b1, 1'b0, 1023, 0); check("rd1023", {24'd0, data_out}, 32'd254);
        step(1'b0, 1'b1, 1'b0, 0, 0);    check("rd0",    {24'd0, data_out}, 32'd0);

        // Pseudorandom reads of the fill pattern
        void'($urandom(35));
        for (int i = 0; i < 20; i++) begin
            a = int'($urandom % DEPTH);
            step(1'b0, 1'b1, 1'b0, a, 0);
            check("rand_rd", {24'd0, data_out}, 32'((2 * a) % 256));
        end

        // Deselected write must not land and must not disturb data_out
        step(1'b0, 1'b1, 1'b0, 37, 0);
        held = data_out;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 5, 'hAA);
            check("desel_hold", {24'd0, data_out}, {24'd0, held});
        end
        step(1'b0, 1'b1, 1'b0, 5, 0);
        check("rd5_after_desel", {24'd0, data_out}, 32'd10);

        // Reset mid-sweep restarts it; writes during busy are dropped
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("reset2_dout", {24'd0, data_out}, 32'd0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        check("midsweep_rst_dout", {24'd0, data_out}, 32'd0);
        check("midsweep_rst_busy", {31'd0, busy}, 32'd1);
        wait_sweep(cycles);
        check("sweep_len_restart", cycles, 1024);
        step(1'b0, 1'b1, 1'b0, 9, 0);
        check("rd9_after_busy_write", {24'd0, data_out}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 37, 0);
        check("rd37_cleared", {24'd0, data_out}, 32'd0);

        // Random mixed traffic against the model, biased toward the top address
        for (int i = 0; i < 600; i++) begin
            a = ($urandom % 8 == 0) ? DEPTH - 1 : int'($urandom % DEPTH);
            step(1'b0, ($urandom % 4) != 0, $urandom % 2 == 1, a, int'($urandom % 256));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ram
